bitser_shift_reg: RTL and testbench

Parametrised bit-serial shift register for the bit-serial CPU datapath: register file entries, accumulator and operand latches. It extends the basic load/shift register with several capabilities:
- a multi-bit digit per cycle
- a configurable input-alignment delay for ALU result write-back
- four serial modes (shift-in, rotate, logical and arithmetic shift-out)
- a self-timed beat counter with busy/done handshake

---
 rtl/bitser_shift_reg.sv | 117 +++++++++++
 tb/tb_bitser_shift_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bitser_shift_reg.sv
// Bit-serial shift register with digit-wide beats, four serial modes, an input
// alignment delay for write-back, and a self-timed beat counter with busy/done.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | accepts load (priority) or start
// ST_BUSY | shifting one digit per beat until final beat
module bitser_shift_reg #(
  parameter int WIDTH    = 8,
  parameter int DIGIT    = 1,
  parameter int IN_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DIGIT-1:0] serial_in,
  output logic [DIGIT-1:0] serial_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam int BEATS = WIDTH / DIGIT;
  localparam int CW    = $clog2(BEATS + 4);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_SHIN  = CW'(BEATS - 1 + IN_DELAY);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] M_SHIN  = 2'b00;
  localparam logic [1:0] M_ROT   = 2'b01;
  localparam logic [1:0] M_LOGIC = 2'b10;

  logic [0:0]             state;
  logic [CW-1:0]          cnt;
  logic [1:0]             mode_q;
  logic [DIGIT-1:0]       dly_out;
  logic                   priming;
  logic [DIGIT-1:0]       fill;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [CW-1:0]          last;

  generate
    if (IN_DELAY == 0) begin : g_nodly
      assign dly_out = serial_in;
      assign priming = 1'b0;
    end else begin : g_dly
      logic [DIGIT-1:0] dly [IN_DELAY];

      // The delay line runs on every beat so write-back data stays aligned even
      // when it starts arriving before the operation does.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < IN_DELAY; i++) dly[i] <= '0;
        end else if (en) begin
          dly[0] <= serial_in;
          for (int i = 1; i < IN_DELAY; i++) dly[i] <= dly[i-1];
        end
      end

      assign dly_out = dly[IN_DELAY-1];
      assign priming = (mode_q == M_SHIN) && (cnt < CW'(IN_DELAY));
    end
  endgenerate

  always_comb begin
    fill = '0;
    case (mode_q)
      M_SHIN:  fill = dly_out;
      M_ROT:   fill = q[DIGIT-1:0];
      M_LOGIC: fill = '0;
      default: fill = {DIGIT{q[WIDTH-1]}};
    endcase
  end

  assign cat        = {fill, q};
  assign last       = (mode_q == M_SHIN) ? LAST_SHIN : LAST_SHIFT;
  assign busy       = (state == ST_BUSY);
  assign serial_out = q[DIGIT-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      q      <= '0;
      cnt    <= '0;
      mode_q <= M_SHIN;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        if (state == ST_IDLE) begin
          if (load) begin
            q <= parallel_in;
          end else if (start) begin
            state  <= ST_BUSY;
            cnt    <= '0;
            mode_q <= mode;
          end
        end else begin
          if (!priming) q <= cat[WIDTH+DIGIT-1:DIGIT];
          if (cnt == last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bitser_shift_reg.sv
// Self-checking bench for bitser_shift_reg: three configurations share stimulus,
// results are predicted from the operation rules with plain arithmetic.
module tb_bitser_shift_reg;

  logic       clk = 1'b0;
  logic       rst, en, load, start;
  logic [1:0] mode;
  logic [7:0] pin;
  logic [1:0] si;

  logic [7:0] q0, q1, q2;
  logic [0:0] so0, so1;
  logic [1:0] so2;
  logic       b0, b1, b2, d0, d1, d2;

  int         tsel = 0;
  logic [7:0] sq, sso;
  logic       sb, sd;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bitser_shift_reg #(.WIDTH(8), .DIGIT(1), .IN_DELAY(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .parallel_in(pin), .start(start),
    .mode(mode), .serial_in(si[0:0]), .serial_out(so0), .q(q0), .busy(b0), .done(d0));

  bitser_shift_reg #(.WIDTH(8), .DIGIT(1), .IN_DELAY(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .parallel_in(pin), .start(start),
    .mode(mode), .serial_in(si[0:0]), .serial_out(so1), .q(q1), .busy(b1), .done(d1));

  bitser_shift_reg #(.WIDTH(8), .DIGIT(2), .IN_DELAY(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .parallel_in(pin), .start(start),
    .mode(mode), .serial_in(si), .serial_out(so2), .q(q2), .busy(b2), .done(d2));

  always_comb begin
    sq = q0; sso = {7'd0, so0}; sb = b0; sd = d0;
    case (tsel)
      1:       begin sq = q1; sso = {7'd0, so1}; sb = b1; sd = d1; end
      2:       begin sq = q2; sso = {6'd0, so2}; sb = b2; sd = d2; end
      default: begin sq = q0; sso = {7'd0, so0}; sb = b0; sd = d0; end
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, tsel, obs, exp);
    end
  endtask

  task automatic pick(input int i);
    tsel = i;
    #1;
  endtask

  // Register contents after s bit positions of the given shift-out mode.
  function automatic logic [7:0] exp_mid(input logic [1:0] md, input logic [7:0] v, input int s);
    logic [15:0] dbl;
    dbl = {v, v};
    case (md)
      2'b01:   return 8'(dbl >> s);
      2'b10:   return v >> s;
      2'b11:   return 8'($signed(v) >>> s);
      default: return v;
    endcase
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    en = 1'b1; load = 1'b0; start = 1'b0;
    while ((b0 | b1 | b2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    assert (!(b0 | b1 | b2)) else begin
      n_fail++;
      $error("FAIL idle_timeout observed busy=%b%b%b expected=000", b0, b1, b2);
    end
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    en = 1'b1; load = 1'b1; start = 1'b0; pin = v;
    @(negedge clk);
    load = 1'b0;
    chk("load_q", sq, v);
  endtask

  task automatic run(input int inst, input logic [1:0] md, input logic [7:0] init,
                     input logic [7:0] word, input int st_at, input int st_len);
    int d, idl, beats, prime, total;
    logic [7:0] mask, fin;
    d     = (inst == 2) ? 2 : 1;
    idl   = (inst == 0) ? 1 : ((inst == 1) ? 0 : 2);
    beats = 8 / d;
    prime = (md == 2'b00) ? idl : 0;
    total = beats + prime;
    mask  = (inst == 2) ? 8'h03 : 8'h01;
    case (md)
      2'b00:   fin = word;
      2'b01:   fin = init;
      2'b10:   fin = 8'h00;
      default: fin = {8{init[7]}};
    endcase

    wait_idle();
    pick(inst);
    do_load(init);
    start = 1'b1; mode = md; si = 2'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 8'(sb), 8'h01);

    for (int b = 0; b < total; b++) begin
      if (b == st_at && st_len > 0) begin
        en = 1'b0;
        for (int k = 0; k < st_len; k++) begin
          load = 1'b1; start = 1'b1; pin = 8'($urandom);
          @(negedge clk);
          chk("stall_busy", 8'(sb), 8'h01);
          chk("stall_done", 8'(sd), 8'h00);
          if (md != 2'b00) begin
            chk("stall_q", sq, exp_mid(md, init, b * d));
            chk("stall_so", sso, (init >> (b * d)) & mask);
          end
        end
        en = 1'b1;
      end
      load  = 1'($urandom);
      start = 1'($urandom);
      mode  = 2'($urandom);
      pin   = 8'($urandom);
      si    = (b < beats) ? 2'((word >> (b * d)) & mask) : 2'($urandom);
      if (md != 2'b00) chk("so", sso, (init >> (b * d)) & mask);
      chk("busy", 8'(sb), 8'h01);
      chk("done_early", 8'(sd), 8'h00);
      @(negedge clk);
    end
    load = 1'b0; start = 1'b0;
    chk("fin_busy", 8'(sb), 8'h00);
    chk("fin_done", 8'(sd), 8'h01);
    chk("fin_q", sq, fin);
    en = 1'b0;
    @(negedge clk);
    chk("done_clear", 8'(sd), 8'h00);
    chk("hold_q", sq, fin);
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; mode = 2'b00; pin = 8'h00; si = 2'b00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pick(i);
      chk("rst_q", sq, 8'h00);
      chk("rst_so", sso, 8'h00);
      chk("rst_busy", 8'(sb), 8'h00);
      chk("rst_done", 8'(sd), 8'h00);
    end
    rst = 1'b0; en = 1'b1;
    @(negedge clk);

    run(0, 2'b01, 8'hA5, 8'h00, -1, 0);
    run(0, 2'b00, 8'h00, 8'h3C, -1, 0);
    run(1, 2'b00, 8'hFF, 8'h3C, -1, 0);
    run(2, 2'b11, 8'h96, 8'h00, -1, 0);
    run(2, 2'b10, 8'h96, 8'h00, -1, 0);
    run(2, 2'b00, 8'h00, 8'hC9, -1, 0);
    run(0, 2'b01, 8'hA5, 8'h00, 4, 3);

    // Load wins over start when both arrive while idle.
    wait_idle();
    pick(0);
    load = 1'b1; start = 1'b1; mode = 2'b01; pin = 8'h3E;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("prio_q", sq, 8'h3E);
    chk("prio_busy", 8'(sb), 8'h00);
    @(negedge clk);
    chk("prio_busy2", 8'(sb), 8'h00);

    // Reset at beat 4 of a rotate aborts without a done pulse.
    wait_idle();
    pick(0);
    do_load(8'hA5);
    start = 1'b1; mode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_q", sq, exp_mid(2'b01, 8'hA5, 4));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", sq, 8'h00);
    chk("abort_busy", 8'(sb), 8'h00);
    chk("abort_done", 8'(sd), 8'h00);
    @(negedge clk);
    chk("abort_done2", 8'(sd), 8'h00);
    do_load(8'h5A);

    for (int r = 0; r < 10; r++) begin
      run($urandom_range(0, 2), 2'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 5), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
